// File: rtl/aes_ks_round_ctrl.sv
// aes_ks_round_ctrl: sequencer for a pipelined, masked AES-128 key schedule.
// Walks ten rounds of LATENCY+1 cycles each and drives the datapath controls.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      request a new key expansion (sampled only in IDLE)
//   busy       expansion in progress (ROUND and DONE)
//   key_sel    1 = load external masked key, 0 = feed back round key
//   key_cap    round-key register capture enable
//   sh_RCON    masked RCON, share 0 in [7:0], other shares zero
//   rnd_en     fresh S-box randomness required
//   rk_valid   round key rk_idx is held in the round-key register
//   rk_idx     index (1..10) of the presented round key
//   done       pulses with the presentation of round key 10
//
// Optional feature, macro AES_KS_STALL_EN:
//   rk_ready   consumer accepts the presented round key
//   ks_en      datapath / randomness clock enable, low while stalled
module aes_ks_round_ctrl #(
    parameter int d       = 2,
    parameter int LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           key_sel,
    output logic           key_cap,
    output logic [8*d-1:0] sh_RCON,
    output logic           rnd_en,
    output logic           rk_valid,
    output logic [3:0]     rk_idx,
    output logic           done
`ifdef AES_KS_STALL_EN
    ,
    input  logic           rk_ready,
    output logic           ks_en
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] rnd;
    logic [7:0] rcon;

    state_t     state_n;
    logic [3:0] cnt_n;
    logic [3:0] rnd_n;
    logic [7:0] rcon_n;
    logic       rkv_n;
    logic [3:0] rki_n;
    logic       done_n;
    logic       stall;

    // RCON of the next round: GF(2^8) doubling mod x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

`ifdef AES_KS_STALL_EN
    // A presented key that is not taken freezes the whole sequencer
    assign stall = rk_valid & ~rk_ready;
    assign ks_en = busy & ~stall;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rnd_n   = rnd;
        rcon_n  = rcon;
        rkv_n   = 1'b0;
        rki_n   = rk_idx;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = ROUND;
                    cnt_n   = 4'd0;
                    rnd_n   = 4'd1;
                    rcon_n  = 8'h01;
                end
            end
            ROUND: begin
                if (cnt == LAT) begin
                    // round key captured this cycle, present it next cycle
                    cnt_n = 4'd0;
                    rkv_n = 1'b1;
                    rki_n = rnd;
                    if (rnd == 4'd10) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        rnd_n  = rnd + 4'd1;
                        rcon_n = xtime(rcon);
                    end
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so that they
    // line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rnd      <= 4'd1;
            rcon     <= 8'h01;
            busy     <= 1'b0;
            key_sel  <= 1'b0;
            key_cap  <= 1'b0;
            rnd_en   <= 1'b0;
            rk_valid <= 1'b0;
            rk_idx   <= 4'd0;
            done     <= 1'b0;
        end else if (!stall) begin
            state    <= state_n;
            cnt      <= cnt_n;
            rnd      <= rnd_n;
            rcon     <= rcon_n;
            busy     <= (state_n != IDLE);
            key_sel  <= (state_n == ROUND) && (rnd_n == 4'd1)
                        && (cnt_n == 4'd0);
            key_cap  <= (state_n == ROUND) && (cnt_n == LAT);
            rnd_en   <= (state_n == ROUND) && (cnt_n < LAT);
            rk_valid <= rkv_n;
            rk_idx   <= rki_n;
            done     <= done_n;
        end
    end

    // Only share 0 carries RCON; decoded from registered state
    always_comb begin
        sh_RCON = '0;
        if (state == ROUND && cnt == LAT) begin
            sh_RCON[7:0] = rcon;
        end
    end

endmodule

// File: tb/tb_aes_ks_round_ctrl.sv
// tb_aes_ks_round_ctrl: directed bench for aes_ks_round_ctrl.
// Runs LATENCY=4 and LATENCY=1 instances against a per-cycle expectation.
module tb_aes_ks_round_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0;
    logic        start1 = 1'b0;

    logic        busy4, ksel4, kcap4, rnden4, rkv4, done4;
    logic [15:0] sh4;
    logic [3:0]  idx4;
    logic        busy1, ksel1, kcap1, rnden1, rkv1, done1;
    logic [15:0] sh1;
    logic [3:0]  idx1;
`ifdef AES_KS_STALL_EN
    logic        rk_ready4 = 1'b1;
    logic        rk_ready1 = 1'b1;
    logic        ks_en4, ks_en1;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    always #5 clk = ~clk;

    aes_ks_round_ctrl #(.d(2), .LATENCY(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .busy     (busy4),
        .key_sel  (ksel4),
        .key_cap  (kcap4),
        .sh_RCON  (sh4),
        .rnd_en   (rnden4),
        .rk_valid (rkv4),
        .rk_idx   (idx4),
        .done     (done4)
`ifdef AES_KS_STALL_EN
        ,
        .rk_ready (rk_ready4),
        .ks_en    (ks_en4)
`endif
    );

    aes_ks_round_ctrl #(.d(2), .LATENCY(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .busy     (busy1),
        .key_sel  (ksel1),
        .key_cap  (kcap1),
        .sh_RCON  (sh1),
        .rnd_en   (rnden1),
        .rk_valid (rkv1),
        .rk_idx   (idx1),
        .done     (done1)
`ifdef AES_KS_STALL_EN
        ,
        .rk_ready (rk_ready1),
        .ks_en    (ks_en1)
`endif
    );

    // bit layout: busy[0] ksel[1] kcap[2] rnd_en[3] rkv[4] done[5]
    //             idx[9:6] sh[25:10]
    logic [25:0] o4, o1;
    assign o4 = {sh4, idx4, done4, rkv4, rnden4, kcap4, ksel4, busy4};
    assign o1 = {sh1, idx1, done1, rkv1, rnden1, kcap1, ksel1, busy1};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [25:0] o);
        chk({tag, ".busy"}, 32'(o[0]), 0);
        chk({tag, ".ksel"}, 32'(o[1]), 0);
        chk({tag, ".kcap"}, 32'(o[2]), 0);
        chk({tag, ".rnden"}, 32'(o[3]), 0);
        chk({tag, ".rkv"}, 32'(o[4]), 0);
        chk({tag, ".done"}, 32'(o[5]), 0);
        chk({tag, ".sh"}, 32'(o[25:10]), 0);
    endtask

    // Called at a negedge with start already driven; checks every cycle
    // of one expansion, cycle 1 being the one after the accept edge.
    task automatic check_run(input int lat, input bit sel1,
                             input bit drop_start);
        int n;
        int r, c;
        logic [25:0] o;
        logic e_ksel, e_kcap, e_rnden, e_rkv, e_done;
        logic [7:0] e_sh;
        logic [3:0] e_idx;
        n = 10 * (lat + 1) + 1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (drop_start && k == 1) begin
                start4 = 1'b0;
                start1 = 1'b0;
            end
            o = sel1 ? o1 : o4;
            if (k < n) begin
                r = (k - 1) / (lat + 1) + 1;
                c = (k - 1) % (lat + 1);
                e_ksel  = (r == 1 && c == 0);
                e_kcap  = (c == lat);
                e_rnden = (c < lat);
                e_rkv   = (c == 0 && r > 1);
                e_done  = 1'b0;
                e_sh    = e_kcap ? rcon_tab[r-1] : 8'h00;
                e_idx   = 4'(r - 1);
            end else begin
                e_ksel  = 1'b0;
                e_kcap  = 1'b0;
                e_rnden = 1'b0;
                e_rkv   = 1'b1;
                e_done  = 1'b1;
                e_sh    = 8'h00;
                e_idx   = 4'd10;
            end
            chk("run.busy", 32'(o[0]), 1);
            chk("run.ksel", 32'(o[1]), 32'(e_ksel));
            chk("run.kcap", 32'(o[2]), 32'(e_kcap));
            chk("run.rnden", 32'(o[3]), 32'(e_rnden));
            chk("run.rkv", 32'(o[4]), 32'(e_rkv));
            chk("run.done", 32'(o[5]), 32'(e_done));
            chk("run.sh0", 32'(o[17:10]), 32'(e_sh));
            chk("run.sh1", 32'(o[25:18]), 0);
            if (e_rkv) chk("run.idx", 32'(o[9:6]), 32'(e_idx));
        end
    endtask

    initial begin
        // reset state, sampled while rst is held
        #1;
        chk_idle("rst4", o4);
        chk_idle("rst1", o1);
        chk("rst4.idx", 32'(idx4), 0);
        chk("rst1.idx", 32'(idx1), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle4", o4);

        // single start pulse, LATENCY=4
        start4 = 1'b1;
        check_run(4, 1'b0, 1'b1);
        @(negedge clk);
        chk_idle("post4", o4);

        // start held throughout: one run, then one IDLE cycle, then rerun
        @(negedge clk);
        start4 = 1'b1;
        check_run(4, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold.gap_busy", 32'(busy4), 0);
        check_run(4, 1'b0, 1'b1);
        @(negedge clk);
        chk_idle("hold.post", o4);

        // asynchronous reset at round 6, cnt 2 (cycle 28)
        start4 = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            start4 = 1'b0;
        end
        chk("mid.busy", 32'(busy4), 1);
        chk("mid.rnden", 32'(rnden4), 1);
        #2 rst = 1'b1;
        #1;
        chk_idle("mid.rst", o4);
        chk("mid.idx", 32'(idx4), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_idle("mid.after", o4);
        end
        start4 = 1'b1;
        check_run(4, 1'b0, 1'b1);

        // LATENCY=1 instance
        @(negedge clk);
        start1 = 1'b1;
        check_run(1, 1'b1, 1'b1);
        @(negedge clk);
        chk_idle("post1", o1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
